// File: rtl/y86_pkg.sv
// y86_pkg: Y86-64 icode/stat constants, memory-stage FSM encoding and op-class helpers.
package y86_pkg;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;
  function automatic logic is_read(input logic [3:0] ic);
    return ic == IMRMOVQ || ic == IRET || ic == IPOPQ;
  endfunction
  function automatic logic is_write(input logic [3:0] ic);
    return ic == IRMMOVQ || ic == ICALL || ic == IPUSHQ;
  endfunction
  function automatic logic uses_sp(input logic [3:0] ic);
    return ic == IRET || ic == IPOPQ;
  endfunction
endpackage

// File: rtl/dmem_bytes.sv
// dmem_bytes: byte-addressed data memory with one 8-byte little-endian read port and one write port.
module dmem_bytes #(
  parameter int MEM_BYTES = 1024,
  localparam int AW = $clog2(MEM_BYTES)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] raddr,
  input  logic [AW-1:0] waddr,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);
  logic [7:0] mem [MEM_BYTES];
  always_ff @(posedge clk)
    if (we)
      for (int i = 0; i < 8; i++) mem[waddr + AW'(i)] <= wdata[8*i +: 8];
  always_comb begin
    rdata = '0;
    for (int i = 0; i < 8; i++) rdata[8*i +: 8] = mem[raddr + AW'(i)];
  end
endmodule

// File: rtl/memory_stage.sv
// memory_stage: Y86-64 SEQ memory stage, multi-cycle data access behind valid/ready handshakes.
// Define MEMORY_STAGE_ALIGN_CHECK_EN to treat non-8-byte-aligned accesses as address errors.
module memory_stage import y86_pkg::*; #(
  parameter int MEM_BYTES = 1024,
  parameter int MEM_LAT   = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  icode,
  input  logic [63:0] valE,
  input  logic [63:0] valA,
  input  logic [63:0] valP,
  input  logic [2:0]  stat_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  icode_out,
  output logic [63:0] valE_out,
  output logic [63:0] valM,
  output logic [2:0]  stat_out
);
  localparam int AW = $clog2(MEM_BYTES);
  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d, icode_q, icode_d;
  logic [63:0] valE_q, valE_d, valA_q, valA_d, valP_q, valP_d, valM_q, valM_d;
  logic [2:0]  stat_q, stat_d, stat_out_q, stat_out_d;
  logic [63:0] addr, wdata, rdata;
  logic        accept, go, aok, adr_err, we;
  assign in_ready  = state_q == S_IDLE;
  assign out_valid = state_q == S_RESP;
  assign icode_out = icode_q;
  assign valE_out  = valE_q;
  assign valM      = valM_q;
  assign stat_out  = stat_out_q;
  always_comb begin
    accept  = in_ready && in_valid;
    go      = state_q == S_ACCESS && cnt_q == 4'd0;
    aok     = stat_q == SAOK;
    addr    = uses_sp(icode_q) ? valA_q : valE_q;
    wdata   = icode_q == ICALL ? valP_q : valA_q;
`ifdef MEMORY_STAGE_ALIGN_CHECK_EN
    adr_err = (is_read(icode_q) || is_write(icode_q)) && (addr > 64'(MEM_BYTES - 8) || addr[2:0] != 3'd0);
`else
    adr_err = (is_read(icode_q) || is_write(icode_q)) && addr > 64'(MEM_BYTES - 8);
`endif
    // A reset landing on the resolving edge must abort the write too.
    we      = go && aok && is_write(icode_q) && !adr_err && !Rst;
    state_d = accept ? S_ACCESS : go ? S_RESP : (out_valid && out_ready) ? S_IDLE : state_q;
    cnt_d   = accept ? 4'(MEM_LAT - 1) : (state_q == S_ACCESS && !go) ? cnt_q - 4'd1 : cnt_q;
    icode_d = accept ? icode : icode_q;
    valE_d  = accept ? valE : valE_q;
    valA_d  = accept ? valA : valA_q;
    valP_d  = accept ? valP : valP_q;
    stat_d  = accept ? stat_in : stat_q;
    valM_d  = go ? ((aok && is_read(icode_q) && !adr_err) ? rdata : 64'd0) : valM_q;
    stat_out_d = go ? ((aok && adr_err) ? SADR : stat_q) : stat_out_q;
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      icode_q    <= '0;
      valE_q     <= '0;
      valA_q     <= '0;
      valP_q     <= '0;
      stat_q     <= SAOK;
      valM_q     <= '0;
      stat_out_q <= SAOK;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      icode_q    <= icode_d;
      valE_q     <= valE_d;
      valA_q     <= valA_d;
      valP_q     <= valP_d;
      stat_q     <= stat_d;
      valM_q     <= valM_d;
      stat_out_q <= stat_out_d;
    end
  end
  dmem_bytes #(.MEM_BYTES(MEM_BYTES)) u_mem (
    .clk  (Clk),
    .we   (we),
    .raddr(addr[AW-1:0]),
    .waddr(addr[AW-1:0]),
    .wdata(wdata),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed checks of memory_stage run in lockstep on MEM_LAT = 2, 1 and 15 instances.
module tb_memory_stage;
  localparam int N = 3;
  localparam int LATS [N] = '{2, 1, 15};
  logic        Clk = 0, Rst = 1, in_valid = 0, out_ready = 0;
  logic [3:0]  icode = 0;
  logic [63:0] valE = 0, valA = 0, valP = 0;
  logic [2:0]  stat_in = 1;
  logic        in_ready_w [N], out_valid_w [N];
  logic [3:0]  icode_w [N];
  logic [63:0] valE_w [N], valM_w [N];
  logic [2:0]  stat_w [N];
  int checks = 0, failures = 0;
  int lat [N];
  localparam logic [63:0] X1 = 64'h1122334455667788;
  localparam logic [63:0] X2 = 64'hA0A1A2A3A4A5A6A7;
  localparam logic [63:0] X3 = 64'h0102030405060708;

  always #5 Clk = ~Clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    memory_stage #(.MEM_BYTES(1024), .MEM_LAT(LATS[g])) dut (
      .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready_w[g]),
      .icode(icode), .valE(valE), .valA(valA), .valP(valP), .stat_in(stat_in),
      .out_valid(out_valid_w[g]), .out_ready(out_ready), .icode_out(icode_w[g]),
      .valE_out(valE_w[g]), .valM(valM_w[g]), .stat_out(stat_w[g]));
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    for (int k = 0; k < N; k++) begin
      check($sformatf("%s.out_valid[%0d]", tag, k), 64'(out_valid_w[k]), 64'd0);
      check($sformatf("%s.in_ready[%0d]", tag, k), 64'(in_ready_w[k]), 64'd1);
    end
  endtask

  task automatic op(input string tag, input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                    input logic [63:0] p, input logic [2:0] st);
    bit seen [N];
    int nseen;
    icode = ic; valE = e; valA = a; valP = p; stat_in = st; in_valid = 1;
    @(posedge Clk); #1;
    in_valid = 0;
    nseen = 0;
    for (int k = 0; k < N; k++) begin seen[k] = 0; lat[k] = 0; end
    for (int c = 1; c <= 40 && nseen < N; c++) begin
      for (int k = 0; k < N; k++)
        if (!seen[k] && out_valid_w[k]) begin seen[k] = 1; lat[k] = c; nseen++; end
      if (nseen < N) begin @(posedge Clk); #1; end
    end
    for (int k = 0; k < N; k++)
      check($sformatf("%s.latency[%0d]", tag, k), 64'(lat[k]), 64'(LATS[k] + 1));
  endtask

  task automatic chk_res(input string tag, input logic [63:0] ev, input logic [2:0] es,
                         input logic [3:0] eic, input logic [63:0] ee);
    for (int k = 0; k < N; k++) begin
      check($sformatf("%s.valM[%0d]", tag, k), valM_w[k], ev);
      check($sformatf("%s.stat[%0d]", tag, k), 64'(stat_w[k]), 64'(es));
      check($sformatf("%s.icode[%0d]", tag, k), 64'(icode_w[k]), 64'(eic));
      check($sformatf("%s.valE[%0d]", tag, k), valE_w[k], ee);
    end
  endtask

  task automatic release_out(input string tag);
    out_ready = 1;
    @(posedge Clk); #1;
    out_ready = 0;
    chk_idle(tag);
  endtask

  initial begin
    repeat (2) @(posedge Clk);
    #1 Rst = 0;
    chk_idle("reset");
    chk_res("reset", 64'd0, 3'd1, 4'd0, 64'd0);

    op("wr40", 4'h4, 64'h40, X1, 64'h0, 3'd1);
    chk_res("wr40", 64'd0, 3'd1, 4'h4, 64'h40);
    release_out("wr40");
    op("rd40", 4'h5, 64'h40, 64'h0, 64'h0, 3'd1);
    chk_res("rd40", X1, 3'd1, 4'h5, 64'h40);
    release_out("rd40");

    // Reset during ACCESS of a write must leave memory untouched.
    icode = 4'h4; valE = 64'h40; valA = 64'hDEADBEEFDEADBEEF; stat_in = 3'd1; in_valid = 1;
    @(posedge Clk); #1;
    in_valid = 0; Rst = 1;
    repeat (2) @(posedge Clk);
    #1 Rst = 0;
    chk_idle("rst_mid");
    op("rd40_after_rst", 4'h5, 64'h40, 64'h0, 64'h0, 3'd1);
    chk_res("rd40_after_rst", X1, 3'd1, 4'h5, 64'h40);
    release_out("rd40_after_rst");

    op("wr48", 4'h4, 64'h48, X2, 64'h0, 3'd1);
    release_out("wr48");

    op("call", 4'h8, 64'h3F8, 64'h0, 64'h123, 3'd1);
    chk_res("call", 64'd0, 3'd1, 4'h8, 64'h3F8);
    release_out("call");
    op("ret", 4'h9, 64'h400, 64'h3F8, 64'h0, 3'd1);
    chk_res("ret", 64'h123, 3'd1, 4'h9, 64'h400);
    release_out("ret");
    op("call_oob", 4'h8, 64'h3F9, 64'h0, 64'h456, 3'd1);
    chk_res("call_oob", 64'd0, 3'd3, 4'h8, 64'h3F9);
    release_out("call_oob");
    op("ret_oob", 4'h9, 64'h401, 64'h3F9, 64'h0, 3'd1);
    chk_res("ret_oob", 64'd0, 3'd3, 4'h9, 64'h401);
    release_out("ret_oob");
    op("rd_huge", 4'h5, 64'hFFFFFFFFFFFFFFF8, 64'h0, 64'h0, 3'd1);
    chk_res("rd_huge", 64'd0, 3'd3, 4'h5, 64'hFFFFFFFFFFFFFFF8);
    release_out("rd_huge");
    op("ret_chk", 4'h9, 64'h400, 64'h3F8, 64'h0, 3'd1);
    chk_res("ret_chk", 64'h123, 3'd1, 4'h9, 64'h400);
    release_out("ret_chk");

    // Backpressure: outputs hold and a pending write request is ignored.
    op("bp", 4'h5, 64'h40, 64'h0, 64'h0, 3'd1);
    icode = 4'h4; valE = 64'h40; valA = 64'hBAD0BAD0BAD0BAD0; in_valid = 1;
    for (int c = 0; c < 5; c++) begin
      @(posedge Clk); #1;
      for (int k = 0; k < N; k++) begin
        check($sformatf("bp%0d.valM[%0d]", c, k), valM_w[k], X1);
        check($sformatf("bp%0d.stat[%0d]", c, k), 64'(stat_w[k]), 64'd1);
        check($sformatf("bp%0d.in_ready[%0d]", c, k), 64'(in_ready_w[k]), 64'd0);
        check($sformatf("bp%0d.out_valid[%0d]", c, k), 64'(out_valid_w[k]), 64'd1);
      end
    end
    in_valid = 0;
    release_out("bp");
    op("bp_rd", 4'h5, 64'h40, 64'h0, 64'h0, 3'd1);
    chk_res("bp_rd", X1, 3'd1, 4'h5, 64'h40);
    release_out("bp_rd");

    op("wr100", 4'h4, 64'h100, X3, 64'h0, 3'd1);
    release_out("wr100");
    op("push_hlt", 4'hA, 64'h100, 64'h5555555555555555, 64'h0, 3'd2);
    chk_res("push_hlt", 64'd0, 3'd2, 4'hA, 64'h100);
    release_out("push_hlt");
    op("pop100", 4'hB, 64'h108, 64'h100, 64'h0, 3'd1);
    chk_res("pop100", X3, 3'd1, 4'hB, 64'h108);
    release_out("pop100");
    op("rd_ins", 4'h5, 64'h40, 64'h0, 64'h0, 3'd4);
    chk_res("rd_ins", 64'd0, 3'd4, 4'h5, 64'h40);
    release_out("rd_ins");
    op("opq", 4'h6, 64'h40, 64'h0, 64'h0, 3'd1);
    chk_res("opq", 64'd0, 3'd1, 4'h6, 64'h40);
    release_out("opq");

`ifdef MEMORY_STAGE_ALIGN_CHECK_EN
    op("rd44", 4'h5, 64'h44, 64'h0, 64'h0, 3'd1);
    chk_res("rd44", 64'd0, 3'd3, 4'h5, 64'h44);
    release_out("rd44");
`else
    op("rd44", 4'h5, 64'h44, 64'h0, 64'h0, 3'd1);
    chk_res("rd44", 64'hA4A5A6A711223344, 3'd1, 4'h5, 64'h44);
    release_out("rd44");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
